// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the D/E/M/W pipeline: tracks producer
// records per stage, raises stall on Tuse/Tnew conflicts and picks bypass sources.
module hazard_ctrl #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md,
    input  logic          d_md_start,
    input  logic          d_md_div,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic [1:0]    fwd_m_rt,
    output logic          md_busy
);

    localparam logic [TW-1:0] TUSE_NONE = '1;
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    logic          e_we, e_md_start, e_md_div;
    logic [AW-1:0] e_wa, e_rs, e_rt;
    logic [TW-1:0] e_tnew;
    logic          m_we;
    logic [AW-1:0] m_wa, m_rt;
    logic [TW-1:0] m_tnew;
    logic          w_we;
    logic [AW-1:0] w_wa;
    logic [TW-1:0] w_tnew;
    logic [CW-1:0] busy_cnt;

    function automatic logic hit(input logic we, input logic [AW-1:0] wa,
                                 input logic [AW-1:0] r);
        return we && (wa == r) && (r != '0);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? t : t - T_ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_we       <= 1'b0;
            e_wa       <= '0;
            e_tnew     <= '0;
            e_rs       <= '0;
            e_rt       <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_we       <= 1'b0;
            m_wa       <= '0;
            m_tnew     <= '0;
            m_rt       <= '0;
            w_we       <= 1'b0;
            w_wa       <= '0;
            w_tnew     <= '0;
            busy_cnt   <= '0;
        end else begin
            if (stall) begin
                e_we       <= 1'b0;
                e_wa       <= '0;
                e_tnew     <= '0;
                e_rs       <= '0;
                e_rt       <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_we       <= d_we;
                e_wa       <= d_wa;
                e_tnew     <= d_tnew;
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_md_start <= d_md_start;
                e_md_div   <= d_md_div;
            end
            m_we   <= e_we;
            m_wa   <= e_wa;
            m_tnew <= dec_sat(e_tnew);
            m_rt   <= e_rt;
            w_we   <= m_we;
            w_wa   <= m_wa;
            w_tnew <= dec_sat(m_tnew);
            // a mult/div leaving E reloads the counter even if it is still running
            if (e_md_start)
                busy_cnt <= e_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - CW'(1);
        end
    end

    logic stall_rs, stall_rt, stall_md;

    always_comb begin
        md_busy  = (busy_cnt != '0);
        stall_rs = (d_tuse_rs != TUSE_NONE) &&
                   ((hit(e_we, e_wa, d_rs) && (e_tnew > d_tuse_rs)) ||
                    (hit(m_we, m_wa, d_rs) && (m_tnew > d_tuse_rs)));
        stall_rt = (d_tuse_rt != TUSE_NONE) &&
                   ((hit(e_we, e_wa, d_rt) && (e_tnew > d_tuse_rt)) ||
                    (hit(m_we, m_wa, d_rt) && (m_tnew > d_tuse_rt)));
        stall_md = d_md && (md_busy || e_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    always_comb begin
        fwd_d_rs = 2'd0;
        if (hit(e_we, e_wa, d_rs) && (e_tnew == '0))      fwd_d_rs = 2'd3;
        else if (hit(m_we, m_wa, d_rs) && (m_tnew == '0)) fwd_d_rs = 2'd2;
        else if (hit(w_we, w_wa, d_rs) && (w_tnew == '0)) fwd_d_rs = 2'd1;

        fwd_d_rt = 2'd0;
        if (hit(e_we, e_wa, d_rt) && (e_tnew == '0))      fwd_d_rt = 2'd3;
        else if (hit(m_we, m_wa, d_rt) && (m_tnew == '0)) fwd_d_rt = 2'd2;
        else if (hit(w_we, w_wa, d_rt) && (w_tnew == '0)) fwd_d_rt = 2'd1;

        fwd_e_rs = 2'd0;
        if (hit(m_we, m_wa, e_rs) && (m_tnew == '0))      fwd_e_rs = 2'd2;
        else if (hit(w_we, w_wa, e_rs) && (w_tnew == '0)) fwd_e_rs = 2'd1;

        fwd_e_rt = 2'd0;
        if (hit(m_we, m_wa, e_rt) && (m_tnew == '0))      fwd_e_rt = 2'd2;
        else if (hit(w_we, w_wa, e_rt) && (w_tnew == '0)) fwd_e_rt = 2'd1;

        fwd_m_rt = 2'd0;
        if (hit(w_we, w_wa, m_rt) && (w_tnew == '0))      fwd_m_rt = 2'd1;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Parametrised hazard and forwarding controller for the five-stage pipeline (D/E/M/W).
- Tracks the destination register and remaining Tnew of the instructions in E, M and W using internal stage registers.
- Compares them each cycle against the Tuse of the instruction in D, and raises stall or selects forwarding sources.
- Adds a multi-cycle HI/LO (mult/div) busy counter, so any HI/LO-touching instruction in D stalls while the unit is busy.

## Interface
Parameters:
- AW, 5: register address width.
- TW, 2: Tuse/Tnew width; all-ones Tuse (3) means "operand not used".
- MULT_LAT, 5: busy cycles after a mult leaves E.
- DIV_LAT, 10: busy cycles after a div leaves E; must be ≥ MULT_LAT and < 2^CW.
- CW, 4: busy counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- d_rs, d_rt  in  AW  source registers of the D instruction.
- d_tuse_rs, d_tuse_rt  in  TW  cycles until the operand is needed (0 = D, 1 = E, 2 = M, 3 = unused).
- d_we  in  1  D instruction writes the GPR file.
- d_wa  in  AW  D destination register.
- d_tnew  in  TW  cycles from E entry until the result exists (0 for jal, 1 for ALU ops, 2 for lw).
- d_md  in  1  D instruction reads or writes HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
- d_md_start  in  1  D instruction is mult or div.
- d_md_div  in  1  with d_md_start, selects div latency.
- stall  out  1  freeze PC and the D register, and inject a bubble into E.
- fwd_d_rs, fwd_d_rt  out  2  D-stage operand source: 0 = RF, 1 = W, 2 = M, 3 = E.
- fwd_e_rs, fwd_e_rt  out  2  E-stage operand source: 0 = pipeline register, 1 = W, 2 = M.
- fwd_m_rt  out  2  M-stage store-data source: 0 = pipeline register, 1 = W.
- md_busy  out  1  busy counter nonzero.

## Operation
- Stage records:
  - E holds {we, wa, tnew, rs, rt, md_start, md_div}.
  - M holds {we, wa, tnew, rt}.
  - W holds {we, wa, tnew}.
- Advance on every clock edge:
  - E loads D fields, or a bubble (all zero) when stall = 1.
  - M loads E with tnew decremented, saturating at 0.
  - W loads M with tnew decremented, saturating at 0.
- A record "matches" register r when we = 1, wa = r, and r ≠ 0. Register 0 never stalls and is never forwarded.
- Stall conditions (OR of all):
  - rs: d_tuse_rs ≠ 3, and E matches d_rs with E.tnew > d_tuse_rs, or M matches d_rs with M.tnew > d_tuse_rs.
  - rt: same rule using d_rt and d_tuse_rt.
  - md: d_md = 1 and (md_busy = 1 or E.md_start = 1).
- D forwarding: priority E > M > W. A stage is selected only if it matches and its tnew = 0; otherwise the output is 0.
- E forwarding: M > W, matching the E record's rs/rt, with tnew = 0 required.
- M forwarding: W matching M.rt, with tnew = 0 required.
- Busy counter:
  - On an edge where E.md_start = 1, load DIV_LAT if E.md_div = 1, else MULT_LAT.
  - Otherwise, if nonzero, decrement.
  - md_busy = (counter ≠ 0).
- All outputs are combinational from the stage records, the counter and the D inputs.

## Timing
- Reset (reset = 0, asynchronous) clears all records and the counter. While in reset, md_busy = 0 and all fwd_* = 0; stall = 0.
- Stall is asserted in the same cycle the hazard is visible in D. The bubble appears in E one edge later.
- A lw in E followed by a dependent add (Tuse 1) in D gives exactly 1 stall cycle. After that, fwd_e_* = 1 (W) when the add reaches E.
- A lw followed by a dependent beq (Tuse 0) gives 2 stall cycles, then fwd_d = 1.
- A mult in E makes md_busy rise on the next edge and stay high for MULT_LAT cycles. mfhi in D stalls from the cycle mult is in E through the last busy cycle: MULT_LAT+1 stall cycles.
- Simultaneous load and decrement: load wins.
- A new mult cannot enter E while busy, because d_md stalls it.
- Reset mid-busy: the counter clears immediately and stall drops.

## Test plan
- Reset: hold reset = 0 with d_md = 1. Require md_busy = 0, stall = 0, all fwd = 0. Release reset; the first edge loads E.
- lw $8 then add $9,$8,$8 (Tuse 1,1): stall = 1 for one cycle. Next cycle the add is in E and the lw is in W (tnew 0), giving fwd_e_rs = fwd_e_rt = 1.
- ori $5 (tnew 1) then beq $5,$0 (Tuse 0): 1 stall cycle, then fwd_d_rs = 2 (M). $0 never triggers fwd_d_rt.
- jal (wa 31, tnew 0) then jr $31 in D: no stall, fwd_d_rs = 3 (E).
- mult then mflo, MULT_LAT = 5: stall for 6 cycles, md_busy high for 5 cycles. div: 11 stall cycles.
- sw $3 after lw $3 (Tuse 2): no stall, fwd_m_rt = 1 when the sw is in M. Assert reset mid-div: md_busy = 0 and stall = 0 immediately.
